// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin drain of show-ahead FIFOs onto one
// registered valid/ready stream, tagging each word with its queue index.
module fifo_rr_scheduler #(
  parameter  int NUM_QUEUES = 4,
  parameter  int WIDTH      = 8,
  parameter  int MAX_BURST  = 4,
  localparam int QW         = $clog2(NUM_QUEUES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_QUEUES-1:0]       q_empty_i,
  input  logic [NUM_QUEUES*WIDTH-1:0] q_data_i,
  output logic [NUM_QUEUES-1:0]       q_rd_en_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [QW-1:0]               out_qid_o
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  logic [QW-1:0]   grant;
  logic [QW-1:0]   last_grant;
  logic [BW-1:0]   burst_cnt;

  logic [WIDTH-1:0] q_data_a [NUM_QUEUES];

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_unpack
    assign q_data_a[i] = q_data_i[i*WIDTH +: WIDTH];
  end

  // Walk downwards so the nearest candidate after last_grant wins.
  logic [QW-1:0] next_q;
  logic [QW-1:0] cand;
  logic          any_ready;

  always_comb begin
    next_q    = '0;
    cand      = '0;
    any_ready = 1'b0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      cand = QW'((int'(last_grant) + k) % NUM_QUEUES);
      if (!q_empty_i[cand]) begin
        next_q    = cand;
        any_ready = 1'b1;
      end
    end
  end

  logic slot_free;
  logic grant_empty;
  logic pop;
  logic burst_end;

  assign slot_free   = ~out_valid_o | out_ready_i;
  assign grant_empty = q_empty_i[grant];
  assign pop         = (state == BURST) & slot_free & ~grant_empty;
  assign burst_end   = (pop && burst_cnt == LAST_CNT) || grant_empty;
  assign q_rd_en_o   = pop ? (NUM_QUEUES'(1) << grant) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= QW'(NUM_QUEUES - 1);
      burst_cnt   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_qid_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_ready) begin
            grant     <= next_q;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (pop) burst_cnt <= burst_cnt + 1'b1;
          if (burst_end) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        out_valid_o <= 1'b1;
        out_data_o  <= q_data_a[grant];
        out_qid_o   <= grant;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
